// File: rtl/mwrite_if.sv
// MMU store-request bus between the memory-write stage (master) and the MMU (slave).
// The master issues a word-aligned, byte-strobed write and holds it until wdone.
interface mwrite_if;
    logic        wren;
    logic [31:0] waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wdone;

    modport master (output wren, waddr, wstrb, wdata, input wdone);
    modport slave  (input wren, waddr, wstrb, wdata, output wdone);
endinterface

// File: rtl/mwrite.sv
// Memory-write pipeline stage. Latches the memory-read commit bundle, issues
// aligned stores to the MMU, stalls upstream until each store completes (or
// times out), and forwards the committed bundle to writeback.
// Optional build macro MWRITE_MISALIGN_CHECK_EN: stores whose shifted strobe
// spills past byte 3 are rejected with a one-cycle bus error instead of issued.
module mwrite #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        MEM_WAIT,
    input  logic [4:0]  MEMR_REG_W_RD,
    input  logic [31:0] MEMR_REG_W_DATA,
    input  logic        MEMR_CSR_W_EN,
    input  logic [11:0] MEMR_CSR_W_ADDR,
    input  logic [31:0] MEMR_CSR_W_DATA,
    input  logic        MEMR_MEM_W_EN,
    input  logic [3:0]  MEMR_MEM_W_STRB,
    input  logic [31:0] MEMR_MEM_W_ADDR,
    input  logic [31:0] MEMR_MEM_W_DATA,
    input  logic        MEMR_JMP_DO,
    input  logic [31:0] MEMR_JMP_PC,
    mwrite_if.master    data,
    output logic        MEMW_WAIT,
    output logic        MEMW_BUS_ERR,
    output logic [4:0]  MEMW_REG_W_RD,
    output logic [31:0] MEMW_REG_W_DATA,
    output logic        MEMW_CSR_W_EN,
    output logic [11:0] MEMW_CSR_W_ADDR,
    output logic [31:0] MEMW_CSR_W_DATA,
    output logic        MEMW_JMP_DO,
    output logic [31:0] MEMW_JMP_PC
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [4:0]  reg_rd;
        logic [31:0] reg_data;
        logic        csr_en;
        logic [11:0] csr_addr;
        logic [31:0] csr_data;
        logic        jmp_do;
        logic [31:0] jmp_pc;
    } bundle_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    bundle_t     stage;
    bundle_t     bundle_in;
    bundle_t     wb_out;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic        bus_err;
    logic [3:0]  strb_shift;
    logic        misalign;
    logic [31:0] wdata_shift;

    assign bundle_in = '{
        reg_rd:   MEMR_REG_W_RD,
        reg_data: MEMR_REG_W_DATA,
        csr_en:   MEMR_CSR_W_EN,
        csr_addr: MEMR_CSR_W_ADDR,
        csr_data: MEMR_CSR_W_DATA,
        jmp_do:   MEMR_JMP_DO,
        jmp_pc:   MEMR_JMP_PC
    };

`ifdef MWRITE_MISALIGN_CHECK_EN
    logic [7:0] strb_wide;
    assign strb_wide  = {4'b0000, MEMR_MEM_W_STRB} << MEMR_MEM_W_ADDR[1:0];
    assign strb_shift = strb_wide[3:0];
    assign misalign   = |strb_wide[7:4];
`else
    // Without the check, bytes shifted past lane 3 are simply dropped.
    assign strb_shift = MEMR_MEM_W_STRB << MEMR_MEM_W_ADDR[1:0];
    assign misalign   = 1'b0;
`endif

    assign wdata_shift = MEMR_MEM_W_DATA << {MEMR_MEM_W_ADDR[1:0], 3'b000};
    assign cnt_next    = cnt + 8'd1;

    // Stage registers, MMU request registers, timeout counter and IDLE/BUSY FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            stage      <= '0;
            cnt        <= '0;
            bus_err    <= 1'b0;
            data.wren  <= 1'b0;
            data.waddr <= '0;
            data.wstrb <= '0;
            data.wdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (FLUSH || MEM_WAIT) begin
                        // A held upstream bundle becomes a bubble so it commits once.
                        stage <= '0;
                    end else begin
                        stage <= bundle_in;
                        if (MEMR_MEM_W_EN) begin
                            if (misalign) begin
                                bus_err <= 1'b1;
                            end else begin
                                state      <= BUSY;
                                cnt        <= '0;
                                data.wren  <= 1'b1;
                                data.waddr <= {MEMR_MEM_W_ADDR[31:2], 2'b00};
                                data.wstrb <= strb_shift;
                                data.wdata <= wdata_shift;
                            end
                        end
                    end
                end
                BUSY: begin
                    // FLUSH is ignored here: the store in flight predates the flush source.
                    if (data.wdone) begin
                        state      <= IDLE;
                        data.wren  <= 1'b0;
                        data.waddr <= '0;
                        data.wstrb <= '0;
                        data.wdata <= '0;
                    end else if ((TIMEOUT != 0) && (cnt_next == TIMEOUT_CNT)) begin
                        state      <= IDLE;
                        bus_err    <= 1'b1;
                        data.wren  <= 1'b0;
                        data.waddr <= '0;
                        data.wstrb <= '0;
                        data.wdata <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writeback outputs are muted while a store is in flight so nothing commits early.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        wb_out = stage;
        if (state == BUSY) begin
            wb_out = '0;
        end
    end

    assign MEMW_WAIT       = (state == BUSY);
    assign MEMW_BUS_ERR    = bus_err;
    assign MEMW_REG_W_RD   = wb_out.reg_rd;
    assign MEMW_REG_W_DATA = wb_out.reg_data;
    assign MEMW_CSR_W_EN   = wb_out.csr_en;
    assign MEMW_CSR_W_ADDR = wb_out.csr_addr;
    assign MEMW_CSR_W_DATA = wb_out.csr_data;
    assign MEMW_JMP_DO     = wb_out.jmp_do;
    assign MEMW_JMP_PC     = wb_out.jmp_pc;

endmodule

// File: tb/tb_mwrite.sv
// Directed testbench for mwrite (TIMEOUT=4). Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
module tb_mwrite;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        mem_wait = 1'b0;
    logic [4:0]  memr_rd = '0;
    logic [31:0] memr_rdata = '0;
    logic        memr_csr_en = 1'b0;
    logic [11:0] memr_csr_addr = '0;
    logic [31:0] memr_csr_data = '0;
    logic        memr_mem_en = 1'b0;
    logic [3:0]  memr_strb = '0;
    logic [31:0] memr_addr = '0;
    logic [31:0] memr_wdata = '0;
    logic        memr_jmp_do = 1'b0;
    logic [31:0] memr_jmp_pc = '0;

    logic        memw_wait;
    logic        memw_bus_err;
    logic [4:0]  memw_rd;
    logic [31:0] memw_rdata;
    logic        memw_csr_en;
    logic [11:0] memw_csr_addr;
    logic [31:0] memw_csr_data;
    logic        memw_jmp_do;
    logic [31:0] memw_jmp_pc;

    int tests = 0;
    int failed = 0;

    mwrite_if bus ();

    mwrite #(.TIMEOUT(4)) dut (
        .CLK             (clk),
        .RST             (rst),
        .FLUSH           (flush),
        .MEM_WAIT        (mem_wait),
        .MEMR_REG_W_RD   (memr_rd),
        .MEMR_REG_W_DATA (memr_rdata),
        .MEMR_CSR_W_EN   (memr_csr_en),
        .MEMR_CSR_W_ADDR (memr_csr_addr),
        .MEMR_CSR_W_DATA (memr_csr_data),
        .MEMR_MEM_W_EN   (memr_mem_en),
        .MEMR_MEM_W_STRB (memr_strb),
        .MEMR_MEM_W_ADDR (memr_addr),
        .MEMR_MEM_W_DATA (memr_wdata),
        .MEMR_JMP_DO     (memr_jmp_do),
        .MEMR_JMP_PC     (memr_jmp_pc),
        .data            (bus),
        .MEMW_WAIT       (memw_wait),
        .MEMW_BUS_ERR    (memw_bus_err),
        .MEMW_REG_W_RD   (memw_rd),
        .MEMW_REG_W_DATA (memw_rdata),
        .MEMW_CSR_W_EN   (memw_csr_en),
        .MEMW_CSR_W_ADDR (memw_csr_addr),
        .MEMW_CSR_W_DATA (memw_csr_data),
        .MEMW_JMP_DO     (memw_jmp_do),
        .MEMW_JMP_PC     (memw_jmp_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] rdata,
                         input logic csr_en, input logic [11:0] csr_addr,
                         input logic [31:0] csr_data, input logic mem_en,
                         input logic [3:0] strb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic jmp_do,
                         input logic [31:0] jmp_pc);
        memr_rd       = rd;
        memr_rdata    = rdata;
        memr_csr_en   = csr_en;
        memr_csr_addr = csr_addr;
        memr_csr_data = csr_data;
        memr_mem_en   = mem_en;
        memr_strb     = strb;
        memr_addr     = addr;
        memr_wdata    = wdata;
        memr_jmp_do   = jmp_do;
        memr_jmp_pc   = jmp_pc;
    endtask

    task automatic clear_inputs();
        drive(5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wdone = 1'b0;

        // Reset state
        #12;
        check("rst_wren",    32'(bus.wren), 0);
        check("rst_wait",    32'(memw_wait), 0);
        check("rst_bus_err", 32'(memw_bus_err), 0);
        check("rst_rd",      32'(memw_rd), 0);
        check("rst_jmp_pc",  memw_jmp_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Non-store bundle passes through the cycle after it is latched
        drive(5'd5, 32'h55, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h80);
        tick();
        check("pass_rd",    32'(memw_rd), 5);
        check("pass_data",  memw_rdata, 32'h55);
        check("pass_jmp",   32'(memw_jmp_do), 1);
        check("pass_pc",    memw_jmp_pc, 32'h80);
        check("pass_wren",  32'(bus.wren), 0);
        check("pass_wait",  32'(memw_wait), 0);
        clear_inputs();
        tick();
        check("pass_once_rd", 32'(memw_rd), 0);

        // Same bundle held with MEM_WAIT for two cycles commits exactly once
        drive(5'd5, 32'h55, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h80);
        mem_wait = 1'b1;
        tick();
        check("hold1_rd", 32'(memw_rd), 0);
        tick();
        check("hold2_rd", 32'(memw_rd), 0);
        mem_wait = 1'b0;
        tick();
        check("hold_commit_rd", 32'(memw_rd), 5);
        check("hold_commit_pc", memw_jmp_pc, 32'h80);
        clear_inputs();
        tick();
        check("hold_after_rd", 32'(memw_rd), 0);

        // Word store, WDONE in the third BUSY cycle
        drive(5'd7, 32'h77, 1'b0, 12'h0, 32'h0, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0);
        tick();
        check("word_wren",  32'(bus.wren), 1);
        check("word_waddr", bus.waddr, 32'h1000);
        check("word_wstrb", 32'(bus.wstrb), 32'hF);
        check("word_wdata", bus.wdata, 32'hDEADBEEF);
        check("word_wait1", 32'(memw_wait), 1);
        check("word_muted_rd", 32'(memw_rd), 0);
        tick();
        check("word_wait2", 32'(memw_wait), 1);
        tick();
        check("word_wait3", 32'(memw_wait), 1);
        check("word_wren3", 32'(bus.wren), 1);
        bus.wdone = 1'b1;
        tick();
        bus.wdone = 1'b0;
        check("word_done_wren", 32'(bus.wren), 0);
        check("word_done_wait", 32'(memw_wait), 0);
        check("word_commit_rd", 32'(memw_rd), 7);
        check("word_commit_data", memw_rdata, 32'h77);
        check("word_no_err", 32'(memw_bus_err), 0);
        clear_inputs();
        tick();
        check("word_once_rd", 32'(memw_rd), 0);

        // Byte store at offset 3, then half store at offset 2
        drive(5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b1, 4'h1, 32'h2003, 32'hAB, 1'b0, 32'h0);
        tick();
        check("byte_waddr", bus.waddr, 32'h2000);
        check("byte_wstrb", 32'(bus.wstrb), 32'h8);
        check("byte_wdata", bus.wdata, 32'hAB000000);
        bus.wdone = 1'b1;
        tick();
        bus.wdone = 1'b0;
        check("byte_min_wait", 32'(memw_wait), 0);
        check("byte_min_wren", 32'(bus.wren), 0);
        drive(5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b1, 4'h3, 32'h2002, 32'h1234, 1'b0, 32'h0);
        tick();
        check("half_waddr", bus.waddr, 32'h2000);
        check("half_wstrb", 32'(bus.wstrb), 32'hC);
        check("half_wdata", bus.wdata, 32'h12340000);
        bus.wdone = 1'b1;
        tick();
        bus.wdone = 1'b0;
        clear_inputs();
        tick();

        // FLUSH during BUSY is ignored; the store completes and commits
        drive(5'd9, 32'h99, 1'b0, 12'h0, 32'h0, 1'b1, 4'hF, 32'h4000, 32'h11223344, 1'b0, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("bflush_wren",  32'(bus.wren), 1);
        check("bflush_waddr", bus.waddr, 32'h4000);
        check("bflush_wait",  32'(memw_wait), 1);
        bus.wdone = 1'b1;
        tick();
        bus.wdone = 1'b0;
        check("bflush_done_wren", 32'(bus.wren), 0);
        check("bflush_commit_rd", 32'(memw_rd), 9);
        clear_inputs();
        tick();

        // FLUSH in IDLE turns the incoming bundle (even a store) into a bubble
        drive(5'd5, 32'h55, 1'b0, 12'h0, 32'h0, 1'b1, 4'hF, 32'h5000, 32'h1, 1'b1, 32'h80);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_inputs();
        check("iflush_rd",   32'(memw_rd), 0);
        check("iflush_jmp",  32'(memw_jmp_do), 0);
        check("iflush_pc",   memw_jmp_pc, 0);
        check("iflush_wren", 32'(bus.wren), 0);
        check("iflush_wait", 32'(memw_wait), 0);
        tick();

        // Timeout: WDONE never arrives, WREN held 4 cycles then one BUS_ERR pulse
        drive(5'd3, 32'h33, 1'b0, 12'h0, 32'h0, 1'b1, 4'hF, 32'h6000, 32'h0, 1'b0, 32'h0);
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_wren_%0d", i), 32'(bus.wren), 1);
            check($sformatf("to_noerr_%0d", i), 32'(memw_bus_err), 0);
            tick();
        end
        check("to_bus_err", 32'(memw_bus_err), 1);
        check("to_wren_off", 32'(bus.wren), 0);
        check("to_idle_wait", 32'(memw_wait), 0);
        check("to_commit_rd", 32'(memw_rd), 3);
        tick();
        check("to_err_pulse", 32'(memw_bus_err), 0);
        check("to_after_rd", 32'(memw_rd), 0);

        // Reset asserted mid-BUSY clears outputs immediately
        drive(5'd4, 32'h44, 1'b0, 12'h0, 32'h0, 1'b1, 4'hF, 32'h7000, 32'h5, 1'b1, 32'h90);
        tick();
        clear_inputs();
        check("mrst_pre_wren", 32'(bus.wren), 1);
        rst = 1'b1;
        #1;
        check("mrst_wren",  32'(bus.wren), 0);
        check("mrst_waddr", bus.waddr, 0);
        check("mrst_wait",  32'(memw_wait), 0);
        check("mrst_rd",    32'(memw_rd), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mrst_after_wren", 32'(bus.wren), 0);

        // Word store at offset 1: rejected with the check, truncated without it
        drive(5'd6, 32'h66, 1'b1, 12'h300, 32'h12, 1'b1, 4'hF, 32'h3001, 32'hCAFEBABE, 1'b1, 32'h200);
        tick();
        clear_inputs();
`ifdef MWRITE_MISALIGN_CHECK_EN
        check("mis_wren",     32'(bus.wren), 0);
        check("mis_wait",     32'(memw_wait), 0);
        check("mis_bus_err",  32'(memw_bus_err), 1);
        check("mis_rd",       32'(memw_rd), 6);
        check("mis_csr_en",   32'(memw_csr_en), 1);
        check("mis_csr_addr", 32'(memw_csr_addr), 32'h300);
        check("mis_csr_data", memw_csr_data, 32'h12);
        check("mis_pc",       memw_jmp_pc, 32'h200);
        tick();
        check("mis_err_pulse", 32'(memw_bus_err), 0);
        check("mis_after_rd",  32'(memw_rd), 0);
`else
        check("mis_wren",    32'(bus.wren), 1);
        check("mis_waddr",   bus.waddr, 32'h3000);
        check("mis_wstrb",   32'(bus.wstrb), 32'hE);
        check("mis_wdata",   bus.wdata, 32'hFEBABE00);
        check("mis_no_err",  32'(memw_bus_err), 0);
        bus.wdone = 1'b1;
        tick();
        bus.wdone = 1'b0;
        check("mis_rd",       32'(memw_rd), 6);
        check("mis_csr_en",   32'(memw_csr_en), 1);
        check("mis_csr_addr", 32'(memw_csr_addr), 32'h300);
        check("mis_csr_data", memw_csr_data, 32'h12);
        check("mis_pc",       memw_jmp_pc, 32'h200);
        check("mis_done_err", 32'(memw_bus_err), 0);
        tick();
        check("mis_after_rd", 32'(memw_rd), 0);
`endif

        // WDONE while IDLE is ignored
        bus.wdone = 1'b1;
        tick();
        tick();
        bus.wdone = 1'b0;
        check("idle_wdone_wren", 32'(bus.wren), 0);
        check("idle_wdone_wait", 32'(memw_wait), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
